// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

  // Default gate under test: 4 inputs, truth table 0x616A, two settle cycles.
  localparam int DEF_N_IN          = 4;
  localparam int NUM_MINTERMS      = 2 ** DEF_N_IN;
  localparam int IDX_W             = DEF_N_IN;
  localparam int CNT_W             = DEF_N_IN + 1;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam logic [NUM_MINTERMS-1:0] DEF_EXPECTED_TT = 16'h616A;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Settle counter width; kept at least 1 bit so SETTLE_CYCLES=0 still builds.
  function automatic int settle_w(input int settle_cycles);
    if (settle_cycles > 0) begin
      return $clog2(settle_cycles + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/tt_sweep_settle_timer.sv
// Loadable down-counter that times the settle interval after each minterm drive.
module tt_sweep_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         reach_zero
);

  // Load on request, otherwise count down to zero and stop there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  // zero: counter is idle at 0; reach_zero: this decrement brings it to 0.
  assign zero       = (count == '0);
  assign reach_zero = dec && (count == W'(1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every input minterm of a combinational gate, records its truth table
// and compares it against the expected table.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int                      N_IN          = DEF_N_IN,
  parameter logic [(2**N_IN)-1:0]    EXPECTED_TT   = DEF_EXPECTED_TT,
  parameter int                      SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   gate_out,
  output logic [N_IN-1:0]        gate_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(2**N_IN)-1:0]   captured_tt,
  output logic [N_IN:0]          mismatch_cnt,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail_idx
);

  localparam int NUM_MT = 2 ** N_IN;
  localparam int IW     = N_IN;
  localparam int CW     = N_IN + 1;
  localparam int TW     = settle_w(SETTLE_CYCLES);

  state_e        state_r;
  logic [IW-1:0] idx_r;
  logic [TW-1:0] settle_cnt_s;
  logic          settle_zero_s;
  logic          settle_last_s;
  logic          timer_load_s;
  logic          timer_dec_s;
  logic          mis_s;
  logic [CW-1:0] cnt_next_s;

  assign timer_load_s = (state_r == ST_DRIVE);
  assign timer_dec_s  = (state_r == ST_SETTLE);

  tt_sweep_settle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load_s),
    .load_val   (TW'(SETTLE_CYCLES)),
    .dec        (timer_dec_s),
    .count      (settle_cnt_s),
    .zero       (settle_zero_s),
    .reach_zero (settle_last_s)
  );

  // Compare the live gate output with the expected bit and pre-compute the
  // updated mismatch count so pass can include the final sample.
  always_comb begin
    mis_s      = (gate_out != EXPECTED_TT[idx_r]);
    cnt_next_s = mismatch_cnt;
    if (mis_s) begin
      cnt_next_s = mismatch_cnt + CW'(1);
    end else begin
      cnt_next_s = mismatch_cnt;
    end
  end

  // Sweep FSM with all result registers; abort wins over everything in busy states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      idx_r          <= '0;
      gate_in        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      captured_tt    <= '0;
      mismatch_cnt   <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            captured_tt    <= '0;
            mismatch_cnt   <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
            idx_r          <= '0;
            busy           <= 1'b1;
            state_r        <= ST_DRIVE;
          end else begin
            state_r <= state_r;
          end
        end
        ST_DRIVE, ST_SETTLE, ST_SAMPLE: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            gate_in <= '0;
            pass    <= 1'b0;
            idx_r   <= '0;
          end else if (state_r == ST_DRIVE) begin
            gate_in <= idx_r;
            state_r <= (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_SAMPLE;
          end else if (state_r == ST_SETTLE) begin
            // settle_zero_s is a guard so a stale zero count can never stall the sweep
            if (settle_last_s || settle_zero_s) begin
              state_r <= ST_SAMPLE;
            end else begin
              state_r <= ST_SETTLE;
            end
          end else begin
            captured_tt[idx_r] <= gate_out;
            mismatch_cnt       <= cnt_next_s;
            if (mis_s && !fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= idx_r;
            end else begin
              first_fail_idx <= first_fail_idx;
            end
            if (idx_r == IW'(NUM_MT - 1)) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              pass    <= (cnt_next_s == '0);
            end else begin
              idx_r   <= idx_r + IW'(1);
              state_r <= ST_DRIVE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: scoreboarded sweeps against a gate model.
module tb_tt_sweep_ctrl;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic        fv;
    logic [3:0]  ffi;
    logic        pass;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] exp_tt_v = 16'h616A;
  int          gate_mode = 0;   // 0 real gate, 1 stuck at 0, 2 stuck at 1
  int          cyc = 0;
  int          accept_a = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];

  logic        start_a = 1'b0, abort_a = 1'b0, gate_out_a;
  logic [3:0]  gate_in_a, first_fail_idx_a;
  logic        busy_a, done_a, pass_a, fail_valid_a;
  logic [15:0] captured_tt_a;
  logic [4:0]  mismatch_cnt_a;

  logic        start_b = 1'b0, abort_b = 1'b0, gate_out_b;
  logic [3:0]  gate_in_b, first_fail_idx_b;
  logic        busy_b, done_b, pass_b, fail_valid_b;
  logic [15:0] captured_tt_b;
  logic [4:0]  mismatch_cnt_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    gate_out_a = 1'b0;
    gate_out_b = 1'b0;
    case (gate_mode)
      0: begin gate_out_a = exp_tt_v[gate_in_a]; gate_out_b = exp_tt_v[gate_in_b]; end
      1: begin gate_out_a = 1'b0; gate_out_b = 1'b0; end
      default: begin gate_out_a = 1'b1; gate_out_b = 1'b1; end
    endcase
  end

  tt_sweep_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .gate_out(gate_out_a),
    .gate_in(gate_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .captured_tt(captured_tt_a), .mismatch_cnt(mismatch_cnt_a),
    .fail_valid(fail_valid_a), .first_fail_idx(first_fail_idx_a)
  );

  tt_sweep_ctrl #(.SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .gate_out(gate_out_b),
    .gate_in(gate_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .captured_tt(captured_tt_b), .mismatch_cnt(mismatch_cnt_b),
    .fail_valid(fail_valid_b), .first_fail_idx(first_fail_idx_b)
  );

  // Expected sweep result for a gate mode, from the XOR of observed and expected tables.
  function automatic exp_t model(input int mode, input int lat);
    exp_t e;
    logic [15:0] obs, diff;
    obs = (mode == 0) ? exp_tt_v : ((mode == 1) ? 16'h0000 : 16'hFFFF);
    diff = obs ^ exp_tt_v;
    e.tt = obs; e.cnt = 5'd0; e.fv = 1'b0; e.ffi = 4'd0; e.pass = (diff == 16'h0000); e.lat = lat;
    for (int k = 0; k < 16; k++) begin
      if (diff[k]) begin
        e.cnt = e.cnt + 5'd1;
        if (!e.fv) begin e.fv = 1'b1; e.ffi = 4'(k); end
      end
    end
    return e;
  endfunction

  task automatic start_sweep_a(input int mode, input bit push);
    gate_mode = mode;
    if (push) sb_q.push_back(model(mode, 64));
    @(negedge clk); start_a = 1'b1; accept_a = cyc + 1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string name, input bit chk_pulse);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s done: seen=%0d queued=%0d (need a done pulse and a queued expectation)", name, seen, sb_q.size());
      if (sb_q.size() > 0) e = sb_q.pop_front();
      return;
    end
    e = sb_q.pop_front();
    checks++; if (cyc - accept_a != e.lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc - accept_a, e.lat); end
    checks++; if (captured_tt_a !== e.tt) begin errors++; $display("FAIL %s captured_tt: got %h expected %h", name, captured_tt_a, e.tt); end
    checks++; if (mismatch_cnt_a !== e.cnt) begin errors++; $display("FAIL %s mismatch_cnt: got %0d expected %0d", name, mismatch_cnt_a, e.cnt); end
    checks++; if (fail_valid_a !== e.fv) begin errors++; $display("FAIL %s fail_valid: got %b expected %b", name, fail_valid_a, e.fv); end
    checks++; if (first_fail_idx_a !== e.ffi) begin errors++; $display("FAIL %s first_fail_idx: got %0d expected %0d", name, first_fail_idx_a, e.ffi); end
    checks++; if (pass_a !== e.pass) begin errors++; $display("FAIL %s pass: got %b expected %b", name, pass_a, e.pass); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL %s busy at done: got %b expected 0", name, busy_a); end
    if (chk_pulse) begin
      repeat (3) @(negedge clk);
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL %s done width: got %b expected 0", name, done_a); end
      checks++; if (captured_tt_a !== e.tt || pass_a !== e.pass) begin
        errors++; $display("FAIL %s hold: got tt=%h pass=%b expected tt=%h pass=%b", name, captured_tt_a, pass_a, e.tt, e.pass);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gate_in_a, busy_a, done_a, pass_a, captured_tt_a, mismatch_cnt_a, fail_valid_a, first_fail_idx_a} !== 33'd0) begin
      errors++; $display("FAIL reset_a: got gate_in=%h busy=%b tt=%h cnt=%0d expected all zero", gate_in_a, busy_a, captured_tt_a, mismatch_cnt_a);
    end
    checks++;
    if ({gate_in_b, busy_b, done_b, pass_b, captured_tt_b, mismatch_cnt_b, fail_valid_b, first_fail_idx_b} !== 33'd0) begin
      errors++; $display("FAIL reset_b: got gate_in=%h busy=%b tt=%h cnt=%0d expected all zero", gate_in_b, busy_b, captured_tt_b, mismatch_cnt_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep(input int mode, input string name);
    start_sweep_a(mode, 1'b1);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL %s busy after start: got %b expected 1", name, busy_a); end
    wait_done_a(name, 1'b1);
  endtask

  task automatic test_settle0();
    exp_t e;
    int   acc;
    gate_mode = 0;
    sb_q.push_back(model(0, 32));
    @(negedge clk); start_b = 1'b1; acc = cyc + 1;
    @(negedge clk); start_b = 1'b0;
    for (int m = 0; m < 16; m++) begin
      @(negedge clk);
      checks++; if (gate_in_b !== 4'(m)) begin errors++; $display("FAIL settle0 gate_in step %0d: got %0d expected %0d", m, gate_in_b, m); end
      @(negedge clk);
    end
    e = sb_q.pop_front();
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL settle0 done at %0d cycles: got %b expected 1", cyc - acc, done_b); end
    checks++; if (cyc - acc != e.lat) begin errors++; $display("FAIL settle0 latency: got %0d expected %0d", cyc - acc, e.lat); end
    checks++; if (captured_tt_b !== e.tt || pass_b !== e.pass || mismatch_cnt_b !== e.cnt) begin
      errors++; $display("FAIL settle0 result: got tt=%h pass=%b cnt=%0d expected tt=%h pass=%b cnt=%0d",
                         captured_tt_b, pass_b, mismatch_cnt_b, e.tt, e.pass, e.cnt);
    end
    @(negedge clk);
    checks++; if (done_b !== 1'b0 || gate_in_b !== 4'd15) begin
      errors++; $display("FAIL settle0 after done: got done=%b gate_in=%0d expected done=0 gate_in=15", done_b, gate_in_b);
    end
  endtask

  task automatic test_abort();
    bit reached, saw_done;
    reached = 1'b0; saw_done = 1'b0;
    start_sweep_a(0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (gate_in_a === 4'd5) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!reached) begin errors++; $display("FAIL abort reach idx5: got gate_in=%0d expected 5", gate_in_a); end
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0 || gate_in_a !== 4'd0 || pass_a !== 1'b0) begin
      errors++; $display("FAIL abort state: got busy=%b gate_in=%0d pass=%b expected 0 0 0", busy_a, gate_in_a, pass_a);
    end
    for (int i = 0; i < 80; i++) begin
      if (done_a === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_done) begin errors++; $display("FAIL abort no_done: got done pulse expected none"); end
    test_sweep(0, "after_abort");
  endtask

  task automatic test_back_to_back();
    start_sweep_a(0, 1'b1);
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done_a("b2b_first", 1'b0);
    gate_mode = 2;
    sb_q.push_back(model(2, 64));
    start_a = 1'b1; accept_a = cyc + 1;
    @(negedge clk); start_a = 1'b0;
    checks++; if (captured_tt_a !== 16'h0000 || pass_a !== 1'b0 || mismatch_cnt_a !== 5'd0 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++; $display("FAIL b2b clear: got tt=%h pass=%b cnt=%0d busy=%b done=%b expected 0000 0 0 1 0",
                         captured_tt_a, pass_a, mismatch_cnt_a, busy_a, done_a);
    end
    wait_done_a("b2b_second", 1'b1);
  endtask

  task automatic test_reset_mid();
    bit reached, saw_done;
    reached = 1'b0; saw_done = 1'b0;
    start_sweep_a(0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (gate_in_a === 4'd3) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!reached) begin errors++; $display("FAIL rst_mid reach idx3: got gate_in=%0d expected 3", gate_in_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gate_in_a, busy_a, done_a, pass_a, captured_tt_a, mismatch_cnt_a, fail_valid_a, first_fail_idx_a} !== 33'd0) begin
      errors++; $display("FAIL rst_mid outputs: got gate_in=%h busy=%b tt=%h cnt=%0d expected all zero", gate_in_a, busy_a, captured_tt_a, mismatch_cnt_a);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (done_a === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_done || busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid idle: got done_seen=%b busy=%b expected 0 0", saw_done, busy_a); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep(0, "real_gate");
    test_sweep(1, "stuck0");
    test_sweep(2, "stuck1");
    test_settle0();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
Sequencer that exhaustively exercises one synthesized N-input combinational gate netlist (default: the 4-input truth table 0x616A). It drives every input minterm in ascending order, waits a settle interval, samples the gate output and builds the observed truth table. It compares the observed table against the expected table and reports pass/fail, mismatch count and first failing minterm. It sits beside the gate netlist in the design-verification harness and owns the gate inputs while a sweep is running.

Parameters:
N_IN, 4, number of gate inputs; the sweep covers 2**N_IN minterms
EXPECTED_TT, 16'h616A, expected truth table; bit k = required output for minterm k; width 2**N_IN
SETTLE_CYCLES, 2, wait cycles between driving a minterm and sampling; 0 is legal

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a sweep; sampled only in IDLE or DONE
abort  in  1  cancel the running sweep
gate_out  in  1  output of the gate under control
gate_in  out  N_IN  registered drive to gate inputs; bit i drives gate input _i
busy  out  1  high from accepted start until the sweep ends
done  out  1  one-cycle pulse when the sweep completes (not on abort)
pass  out  1  valid after done: captured_tt == EXPECTED_TT
captured_tt  out  2**N_IN  observed truth table
mismatch_cnt  out  N_IN+1  number of minterms differing from expected
fail_valid  out  1  at least one mismatch in the last sweep
first_fail_idx  out  N_IN  lowest mismatching minterm; 0 when fail_valid=0

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; all outputs 0; idx=0; settle counter=0.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start: clear captured_tt, mismatch_cnt, fail_valid, first_fail_idx and pass; set idx=0; busy=1; go to DRIVE.
- DRIVE (1 cycle): gate_in<=idx; load settle counter with SETTLE_CYCLES. Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
- SETTLE: decrement the counter each cycle; go to SAMPLE on the cycle the counter reaches 0.
- SAMPLE (1 cycle):
  - captured_tt[idx]<=gate_out.
  - If gate_out != EXPECTED_TT[idx]: mismatch_cnt++. If fail_valid was 0, set fail_valid=1 and first_fail_idx=idx.
  - If idx == 2**N_IN-1: go to DONE; otherwise idx++ and go to DRIVE.
- Timing: each minterm takes 2+SETTLE_CYCLES cycles. The first done pulse appears 2**N_IN*(2+SETTLE_CYCLES) cycles after the start-accept edge; this is 64 cycles at the defaults.
- On entry to DONE:
  - done=1 for exactly one cycle; busy=0.
  - pass = (mismatch_cnt==0), evaluated including the final sample.
  - All results hold until the next accepted start.
- start while busy is ignored; no queuing.
- DONE + start in the same cycle as the done pulse: treated as a new sweep, and the results are cleared on the next edge.
- abort (any busy state): return to IDLE next edge; busy=0; gate_in=0; no done pulse; results are left partial and pass=0. abort has priority over start in the same cycle.
- Reset mid-sweep: immediate return to the reset values; no done pulse.
- mismatch_cnt cannot wrap: the maximum value is 2**N_IN, which fits in N_IN+1 bits.
- gate_in changes only in DRIVE and on abort/reset; it holds the last minterm while in DONE.

Decomposition:
- Package tt_sweep_pkg: state enum typedef, the N_IN-derived width constants (NUM_MINTERMS, IDX_W, CNT_W) and the default EXPECTED_TT constant.
- One sub-module, tt_sweep_settle_timer: loadable down-counter with a zero flag, width $clog2(SETTLE_CYCLES+1).
- FSM, result registers and comparison stay in tt_sweep_ctrl.

Test Plan:
- Real 0x616A gate, SETTLE_CYCLES=2, pulse start -> done exactly 64 cycles later; captured_tt=16'h616A; pass=1; mismatch_cnt=0; fail_valid=0.
- gate_out forced 0 -> captured_tt=16'h0000; mismatch_cnt=7; fail_valid=1; first_fail_idx=1; pass=0.
- gate_out forced 1 -> captured_tt=16'hFFFF; mismatch_cnt=9; first_fail_idx=0; pass=0.
- SETTLE_CYCLES=0 -> done 32 cycles after start; gate_in steps 0..15 every 2 cycles; the result matches the first scenario.
- Assert abort at idx=5 -> busy low next cycle; gate_in=0; no done pulse. A new start then completes with pass=1.
- start re-pulsed while busy -> ignored, with done still at cycle 64. Assert rst_n low mid-SETTLE -> all outputs 0 immediately.
